// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer (ISDU): Moore FSM that walks the datapath through
// fetch, decode and execute, with a parameterised hold on every memory access state.
module lc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S1, S5, S9, S0, S22, S12,
        S4, S21, S6, S7, S25, S27, S23, S16, P1, P2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state, state_next;
    logic [2:0] wait_cnt;
    logic       in_wait, wait_done;

    // Only JSR is implemented, so the JSR/JSRR select is deliberately ignored.
    logic unused_ir_11;
    assign unused_ir_11 = IR_11;

    assign in_wait   = (state == S33) || (state == S25) || (state == S16);
    assign wait_done = (wait_cnt == WAIT_LAST);

    // NOTE: state and counter use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            // Counter rests at zero outside memory states, so each entry starts from 0.
            wait_cnt <= (in_wait && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    // NOTE: every output and state_next gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state)
            HALTED: if (Run) state_next = S18;
            S18: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                state_next = S33;
            end
            S33, S25: begin
                Mem_OE = 1'b1;
                LD_MDR = wait_done;
                if (wait_done) state_next = (state == S33) ? S35 : S27;
            end
            S35: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                state_next = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_next = S1;
                    4'b0101: state_next = S5;
                    4'b1001: state_next = S9;
                    4'b0000: state_next = S0;
                    4'b1100: state_next = S12;
                    4'b0100: state_next = S4;
                    4'b0110: state_next = S6;
                    4'b0111: state_next = S7;
                    4'b1101: state_next = P1;
                    default: state_next = S18;
                endcase
            end
            S1, S5: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR_5;
                ALUK       = (state == S1) ? 2'b00 : 2'b01;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S18;
            end
            S9: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b10;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S18;
            end
            S0: state_next = BEN ? S22 : S18;
            S22, S21: begin
                ADDR2MUX   = (state == S22) ? 2'b10 : 2'b11;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S18;
            end
            S12: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                PCMUX      = 2'b01;
                LD_PC      = 1'b1;
                state_next = S18;
            end
            S4: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                state_next = S21;
            end
            S6, S7: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_next = (state == S6) ? S25 : S23;
            end
            S27: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S18;
            end
            S23: begin
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                LD_MDR     = 1'b1;
                state_next = S16;
            end
            S16: begin
                Mem_WE = 1'b1;
                if (wait_done) state_next = S18;
            end
            P1: begin
                LD_LED = 1'b1;
                if (Continue) state_next = P2;
            end
            // Wait for Continue to drop so one press runs exactly one instruction.
            P2: if (!Continue) state_next = S18;
            default: state_next = HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: two instances (MEM_WAIT=2 and 3) share stimulus;
// each checked cycle compares the full output bundle against a hand-built per-state value.
module tb_lc3_control_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;
    } out_t;

    typedef enum {
        E_HALT, E_S18, E_MEM, E_MEML, E_S35, E_S32, E_S1, E_S5, E_S9, E_S0, E_S22,
        E_S12, E_S4, E_S21, E_S67, E_S27, E_S23, E_S16, E_P1, E_P2
    } exp_e;

    logic       clk = 1'b0;
    logic       rst_n, run, cont, ir5, ir11, ben;
    logic [3:0] opcode;
    out_t       obs [2];
    int         n_checks = 0;
    int         n_errors = 0;
    int         gate_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;

        lc3_control_fsm #(.MEM_WAIT(g == 0 ? 2 : 3)) u_dut (
            .Clk(clk), .Reset(rst_n), .Run(run), .Continue(cont), .Opcode(opcode),
            .IR_5(ir5), .IR_11(ir11), .BEN(ben),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
            .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
            .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
            .Mem_OE(mem_oe), .Mem_WE(mem_we)
        );

        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, aluk,
                         drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we};
    end

    // Expected output bundle for each state, written straight from the state table.
    function automatic out_t ex(exp_e s, logic i5);
        out_t o = '0;
        case (s)
            E_S18:  begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
            E_MEM:  o.mem_oe = 1;
            E_MEML: begin o.mem_oe = 1; o.ld_mdr = 1; end
            E_S35:  begin o.gate_mdr = 1; o.ld_ir = 1; end
            E_S32:  o.ld_ben = 1;
            E_S1, E_S5: begin
                o.sr1mux = 1; o.sr2mux = i5; o.aluk = (s == E_S1) ? 2'b00 : 2'b01;
                o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
            end
            E_S9:   begin o.sr1mux = 1; o.aluk = 2'b10; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
            E_S22:  begin o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
            E_S12:  begin o.sr1mux = 1; o.aluk = 2'b11; o.gate_alu = 1; o.pcmux = 2'b01; o.ld_pc = 1; end
            E_S4:   begin o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; end
            E_S21:  begin o.addr2mux = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1; end
            E_S67:  begin o.sr1mux = 1; o.addr1mux = 1; o.addr2mux = 2'b01; o.gate_marmux = 1; o.ld_mar = 1; end
            E_S27:  begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
            E_S23:  begin o.aluk = 2'b11; o.gate_alu = 1; o.ld_mdr = 1; end
            E_S16:  o.mem_we = 1;
            E_P1:   o.ld_led = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk(int d, string tag, exp_e s);
        check(tag, 32'(obs[d]), 32'(ex(s, ir5)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From S18: memory wait cycles, IR load, decode.
    task automatic fetch(int d, int w, string tag);
        for (int i = 0; i < w - 1; i++) begin
            tick(); chk(d, {tag, "_s33"}, E_MEM);
        end
        tick(); chk(d, {tag, "_s33_last"}, E_MEML);
        tick(); chk(d, {tag, "_s35"}, E_S35);
        tick(); chk(d, {tag, "_s32"}, E_S32);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if ($countones({obs[d].gate_pc, obs[d].gate_mdr,
                                obs[d].gate_alu, obs[d].gate_marmux}) > 1)
                    gate_err++;
            end
        end
    end

    initial begin
        rst_n = 0; run = 0; cont = 0; opcode = 4'b0001; ir5 = 1; ir11 = 0; ben = 0;
        #3; chk(0, "reset_halt", E_HALT);
        #4 rst_n = 1;
        tick(); chk(0, "halt_no_run", E_HALT);

        // Run, then async reset while in S33 with Mem_OE high.
        run = 1; tick(); run = 0; chk(0, "run_s18", E_S18);
        tick(); chk(0, "pre_rst_s33", E_MEM);
        rst_n = 0; #1; chk(0, "rst_async", E_HALT);
        #2 rst_n = 1;
        tick(); chk(0, "post_rst_halt1", E_HALT);
        tick(); chk(0, "post_rst_halt2", E_HALT);

        // ADD immediate
        run = 1; tick(); run = 0; chk(0, "add_s18", E_S18);
        fetch(0, 2, "add");
        tick(); chk(0, "add_s1", E_S1);
        tick(); chk(0, "add_s18_end", E_S18);

        opcode = 4'b0101; ir5 = 0;
        fetch(0, 2, "and");
        tick(); chk(0, "and_s5", E_S5);
        tick(); chk(0, "and_s18", E_S18);

        opcode = 4'b1001;
        fetch(0, 2, "not");
        tick(); chk(0, "not_s9", E_S9);
        tick(); chk(0, "not_s18", E_S18);

        opcode = 4'b0000; ben = 1;
        fetch(0, 2, "brt");
        tick(); chk(0, "brt_s0", E_S0);
        tick(); chk(0, "brt_s22", E_S22);
        tick(); chk(0, "brt_s18", E_S18);

        ben = 0;
        fetch(0, 2, "brn");
        tick(); chk(0, "brn_s0", E_S0);
        tick(); chk(0, "brn_s18", E_S18);

        opcode = 4'b1100;
        fetch(0, 2, "jmp");
        tick(); chk(0, "jmp_s12", E_S12);
        tick(); chk(0, "jmp_s18", E_S18);

        opcode = 4'b0100;
        fetch(0, 2, "jsr");
        tick(); chk(0, "jsr_s4", E_S4);
        tick(); chk(0, "jsr_s21", E_S21);
        tick(); chk(0, "jsr_s18", E_S18);

        opcode = 4'b0110;
        fetch(0, 2, "ldr");
        tick(); chk(0, "ldr_s6", E_S67);
        tick(); chk(0, "ldr_s25", E_MEM);
        tick(); chk(0, "ldr_s25_last", E_MEML);
        tick(); chk(0, "ldr_s27", E_S27);
        tick(); chk(0, "ldr_s18", E_S18);

        // Unsupported opcode behaves as a NOP.
        opcode = 4'b1010;
        fetch(0, 2, "nop");
        tick(); chk(0, "nop_s18", E_S18);

        // PAUSE: LED held until Continue, held Continue parks in P2.
        opcode = 4'b1101;
        fetch(0, 2, "pause");
        tick(); chk(0, "pause_p1", E_P1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk(0, "pause_p1_hold", E_P1);
        end
        cont = 1;
        tick(); chk(0, "pause_p2", E_P2);
        for (int i = 0; i < 10; i++) begin
            tick(); chk(0, "pause_p2_hold", E_P2);
        end
        cont = 0; opcode = 4'b0001; ir5 = 0;
        tick(); chk(0, "pause_s18", E_S18);
        fetch(0, 2, "after_pause");
        tick(); chk(0, "after_pause_s1", E_S1);
        tick(); chk(0, "after_pause_s18", E_S18);

        // STR on the MEM_WAIT=3 instance.
        rst_n = 0; #1; chk(1, "w3_reset", E_HALT);
        #1 rst_n = 1;
        opcode = 4'b0111; run = 1;
        tick(); run = 0; chk(1, "str_s18", E_S18);
        fetch(1, 3, "str");
        tick(); chk(1, "str_s7", E_S67);
        tick(); chk(1, "str_s23", E_S23);
        for (int i = 0; i < 3; i++) begin
            tick(); chk(1, "str_s16", E_S16);
        end
        tick(); chk(1, "str_s18_end", E_S18);

        // Random instruction stream for the single-bus-driver property.
        for (int i = 0; i < 300; i++) begin
            opcode = 4'($urandom);
            ben    = 1'($urandom_range(0, 1));
            cont   = 1'($urandom_range(0, 1));
            ir5    = 1'($urandom_range(0, 1));
            tick();
        end
        check("one_gate", 32'(gate_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Moore control unit (ISDU) that sequences the LC-3 datapath through fetch, decode and execute.
- Drives every load enable, bus gate, mux select and memory strobe the datapath consumes.
- Receives opcode and branch status back from the datapath.
- Supports ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with a parameterised memory wait so it is not tied to one SRAM timing.

Parameters:
- MEM_WAIT, 2, number of cycles each memory read/write state is held (1..7).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start execution from HALTED.
- Continue  in  1  release from PAUSE (synchronised/debounced upstream).
- Opcode  in  4  IR[15:12].
- IR_5  in  1  immediate select for ADD/AND.
- IR_11  in  1  JSR vs JSRR (only JSR required; IR_11=0 treated as JSR).
- BEN  in  1  registered branch-enable from datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers.
- PCMUX  out  2  00=PC+1, 01=BUS, 10=address adder.
- ADDR2MUX  out  2  00=0, 01=SEXT6, 10=SEXT9, 11=SEXT11.
- ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASSA.
- DRMUX  out  1  0=IR[11:9], 1=R7.
- SR1MUX  out  1  0=IR[11:9], 1=IR[8:6].
- SR2MUX  out  1  0=register, 1=SEXT5.
- ADDR1MUX  out  1  0=PC, 1=SR1.
- Mem_OE  out  1  memory read strobe, active-high; also MIO_EN.
- Mem_WE  out  1  memory write strobe, active-high.

Behaviour:
- Reset low, asynchronous, in any state: state=HALTED, wait counter=0, all outputs 0.
- Outputs are a pure function of state (Moore). Unlisted outputs are 0 in every state.
- At most one Gate* is high in any cycle.
- HALTED: all outputs 0. Run=1 -> S18; else stay.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC. -> S33.
- S33: Mem_OE, held MEM_WAIT cycles; on the last cycle also LD_MDR. -> S35.
- S35: GateMDR, LD_IR. -> S32.
- S32 (decode): LD_BEN. Next state by opcode:
  - 0001 -> S1; 0101 -> S5; 1001 -> S9; 0000 -> S0; 1100 -> S12.
  - 0100 -> S4; 0110 -> S6; 0111 -> S7; 1101 -> P1.
  - Any other opcode -> S18 (executed as a NOP).
- S1/S5: SR1MUX=1, SR2MUX=IR_5, ALUK=00 (S1) or 01 (S5), GateALU, LD_REG, LD_CC, DRMUX=0. -> S18.
- S9: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC. -> S18.
- S0: BEN=1 -> S22; else -> S18.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. -> S18.
- S12: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC. -> S18.
- S4: GatePC, DRMUX=1, LD_REG. -> S21.
- S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC. -> S18.
- S6 (LDR) / S7 (STR): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR. S6 -> S25; S7 -> S23.
- S25: Mem_OE for MEM_WAIT cycles, LD_MDR on the last. -> S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC. -> S18.
- S23: SR1MUX=0, ALUK=11, GateALU, LD_MDR (Mem_OE=0). -> S16.
- S16: Mem_WE for MEM_WAIT cycles. -> S18.
- P1: LD_LED held. Continue=1 -> P2; else stay.
- P2: no loads. Continue=0 -> S18; else stay. One instruction per Continue press; holding Continue never re-enters P1.
- Wait counter:
  - 3 bits; cleared on entry to S33/S25/S16, incremented each cycle there.
  - Exits when count == MEM_WAIT-1.
  - MEM_WAIT=1 gives a single-cycle state.
- Latency with MEM_WAIT=2:
  - Fetch+decode = 5 cycles (S18, S33x2, S35, S32).
  - ADD = 6. LDR = 9. STR = 9. BR taken = 7, not taken = 6.
- Run is ignored outside HALTED. The only return to HALTED is Reset.

Test Plan:
- Reset low mid-S33 with Mem_OE=1 -> all outputs 0 immediately (same cycle, no clock); after release, stay HALTED until Run=1.
- Run pulse, Opcode=0001, IR_5=1 -> states S18,S33,S33,S35,S32,S1. In S1: GateALU=1, SR2MUX=1, ALUK=00, LD_REG=LD_CC=1. Then S18.
- Opcode=0000: BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10; BEN=0 -> S18 directly after S0.
- Opcode=0111 (STR), MEM_WAIT=3 -> S7, S23, then Mem_WE=1 for exactly 3 cycles, then S18. Mem_OE=0 throughout.
- Opcode=1101: LD_LED=1 until Continue=1. Held Continue=1 for 10 cycles stays in P2. Release -> S18 exactly once.
- Opcode=1010 (unsupported) -> S32 then S18, no LD_REG/LD_PC/Mem_WE. Random instruction stream: assert at most one Gate* per cycle.
